// File: rtl/vga_scan_if.sv
// Pixel-side bundle of the VGA scan generator: coordinate export, colour return and DAC pins.
// The generator drives everything except the returned colour.
interface vga_scan_if;
  logic [23:0] pixel_in;
  logic [9:0]  vga_x_cord;
  logic [8:0]  vga_y_cord;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank_n;
  logic        vga_clk;
  logic        frame_start;

  modport master (
    input  pixel_in,
    output vga_x_cord, vga_y_cord, vga_r, vga_g, vga_b,
    output vga_hs, vga_vs, vga_blank_n, vga_clk, frame_start
  );

  modport slave (
    output pixel_in,
    input  vga_x_cord, vga_y_cord, vga_r, vga_g, vga_b,
    input  vga_hs, vga_vs, vga_blank_n, vga_clk, frame_start
  );
endinterface

// File: rtl/vga_scan_generator.sv
// 640x480@60 raster timing generator: publishes the visible coordinate, samples the returned
// colour one pixel later and drives registered colour/sync/blank plus a mid-pixel DAC clock.
module vga_scan_generator #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       vga_reset,
  vga_scan_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW    = $clog2(CLK_DIV);

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);
  localparam logic [9:0]      HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0]      VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0]      HAct    = 10'(H_ACTIVE);
  localparam logic [9:0]      VAct    = 10'(V_ACTIVE);
  localparam logic [9:0]      HsBeg   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]      HsEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]      VsBeg   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]      VsEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      h_q, h_d;
  logic [9:0]      v_q, v_d;
  logic [23:0]     rgb_q, rgb_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            blank_n_q, blank_n_d;
  logic            vclk_q, vclk_d;

  logic pix_en;
  logic active;
  logic hs0;
  logic vs0;

  // Stage 0: region decode straight from the counters.
  always_comb begin
    pix_en = (div_q == DivLast);
    active = (h_q < HAct) && (v_q < VAct);
    hs0    = !((h_q >= HsBeg) && (h_q < HsEnd));
    vs0    = !((v_q >= VsBeg) && (v_q < VsEnd));
  end

  always_comb begin
    div_d     = div_q;
    h_d       = h_q;
    v_d       = v_q;
    rgb_d     = rgb_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    if (vga_reset) begin
      div_d     = '0;
      h_d       = '0;
      v_d       = '0;
      rgb_d     = '0;
      hs_d      = 1'b1;
      vs_d      = 1'b1;
      blank_n_d = 1'b0;
    end else begin
      div_d = pix_en ? '0 : div_q + 1'b1;
      if (pix_en) begin
        h_d = (h_q == HLast) ? '0 : h_q + 10'd1;
        if (h_q == HLast) begin
          v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
        end
        // Stage 1 captures the colour for the coordinate currently on display.
        rgb_d     = active ? vga.pixel_in : '0;
        hs_d      = hs0;
        vs_d      = vs0;
        blank_n_d = active;
      end
    end
    // Registered from the next divider value so it tracks div_cnt without a cycle of lag.
    vclk_d = (div_d >= DivHalf);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      div_q     <= '0;
      h_q       <= '0;
      v_q       <= '0;
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      vclk_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      vclk_q    <= vclk_d;
    end
  end

  assign vga.vga_x_cord  = active ? h_q : 10'd0;
  assign vga.vga_y_cord  = active ? v_q[8:0] : 9'd0;
  assign vga.vga_r       = rgb_q[23:16];
  assign vga.vga_g       = rgb_q[15:8];
  assign vga.vga_b       = rgb_q[7:0];
  assign vga.vga_hs      = hs_q;
  assign vga.vga_vs      = vs_q;
  assign vga.vga_blank_n = blank_n_q;
  assign vga.vga_clk     = vclk_q;
  assign vga.frame_start = pix_en && (h_q == '0) && (v_q == '0) && !vga_reset;

endmodule

// File: tb/tb_vga_scan_generator.sv
// Bench for vga_scan_generator: a default-geometry and a shrunken-geometry instance share random
// colour stimulus and are compared every cycle against a pixel-index arithmetic model.
module tb_vga_scan_generator;

  typedef struct packed {
    int ha, hf, hs, hb, va, vf, vs, vb, dv;
  } geom_t;

  typedef struct packed {
    int          t;
    logic [23:0] rgb;
    logic        hs, vs, bl;
  } mstate_t;

  localparam int B_HA = 20, B_HF = 3, B_HS = 5, B_HB = 4;
  localparam int B_VA = 12, B_VF = 2, B_VS = 2, B_VB = 3, B_DIV = 4;

  localparam geom_t   GA     = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
  localparam geom_t   GB     = '{B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, B_DIV};
  localparam mstate_t MS_RST = '{t: 0, rgb: 24'h0, hs: 1'b1, vs: 1'b1, bl: 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vga_reset;
  logic [23:0] pix;

  int n_checks = 0;
  int n_fail   = 0;
  int gc       = 0;
  int disturb  = 0;

  mstate_t ma = MS_RST;
  mstate_t mb = MS_RST;

  vga_scan_if if_a ();
  vga_scan_if if_b ();
  assign if_a.pixel_in = pix;
  assign if_b.pixel_in = pix;

  vga_scan_generator dut_a (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .vga_reset     (vga_reset),
    .vga           (if_a)
  );

  vga_scan_generator #(
    .H_ACTIVE (B_HA), .H_FP (B_HF), .H_SYNC (B_HS), .H_BP (B_HB),
    .V_ACTIVE (B_VA), .V_FP (B_VF), .V_SYNC (B_VS), .V_BP (B_VB),
    .CLK_DIV  (B_DIV)
  ) dut_b (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .vga_reset     (vga_reset),
    .vga           (if_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int htot(geom_t g);
    return g.ha + g.hf + g.hs + g.hb;
  endfunction

  function automatic int vtot(geom_t g);
    return g.va + g.vf + g.vs + g.vb;
  endfunction

  function automatic int col_of(geom_t g, int t);
    return (t / g.dv) % htot(g);
  endfunction

  function automatic int row_of(geom_t g, int t);
    return (t / g.dv / htot(g)) % vtot(g);
  endfunction

  function automatic bit visible(geom_t g, int h, int v);
    return (h < g.ha) && (v < g.va);
  endfunction

  // One clock edge of the reference: t is clk cycles since the raster last sat at 0,0.
  function automatic mstate_t step(geom_t g, mstate_t m, logic [23:0] pin, logic vr);
    mstate_t n;
    int      h, v;
    n = m;
    h = col_of(g, m.t);
    v = row_of(g, m.t);
    if (vr) begin
      n = MS_RST;
    end else begin
      if (m.t % g.dv == g.dv - 1) begin
        n.bl  = visible(g, h, v);
        n.rgb = visible(g, h, v) ? pin : 24'h0;
        n.hs  = !((h >= g.ha + g.hf) && (h < g.ha + g.hf + g.hs));
        n.vs  = !((v >= g.va + g.vf) && (v < g.va + g.vf + g.vs));
      end
      n.t = m.t + 1;
    end
    return n;
  endfunction

  task automatic check_outputs(input string n, input geom_t g, input mstate_t m, input logic vr,
                               input logic [9:0] x, input logic [8:0] y, input logic [7:0] r,
                               input logic [7:0] gr, input logic [7:0] b, input logic hs,
                               input logic vs, input logic bl, input logic vc, input logic fs);
    int ph, h, v;
    bit act;
    ph  = m.t % g.dv;
    h   = col_of(g, m.t);
    v   = row_of(g, m.t);
    act = visible(g, h, v);
    check({n, ".x_cord"}, 32'(x), act ? h : 0);
    check({n, ".y_cord"}, 32'(y), act ? v : 0);
    check({n, ".r"}, 32'(r), 32'(m.rgb[23:16]));
    check({n, ".g"}, 32'(gr), 32'(m.rgb[15:8]));
    check({n, ".b"}, 32'(b), 32'(m.rgb[7:0]));
    check({n, ".hs"}, 32'(hs), 32'(m.hs));
    check({n, ".vs"}, 32'(vs), 32'(m.vs));
    check({n, ".blank_n"}, 32'(bl), 32'(m.bl));
    check({n, ".vga_clk"}, 32'(vc), 32'(ph >= g.dv / 2));
    check({n, ".frame_start"}, 32'(fs), 32'(ph == g.dv - 1 && h == 0 && v == 0 && !vr));
  endtask

  task automatic check_both();
    check_outputs("a", GA, ma, vga_reset, if_a.vga_x_cord, if_a.vga_y_cord, if_a.vga_r,
                  if_a.vga_g, if_a.vga_b, if_a.vga_hs, if_a.vga_vs, if_a.vga_blank_n,
                  if_a.vga_clk, if_a.frame_start);
    check_outputs("b", GB, mb, vga_reset, if_b.vga_x_cord, if_b.vga_y_cord, if_b.vga_r,
                  if_b.vga_g, if_b.vga_b, if_b.vga_hs, if_b.vga_vs, if_b.vga_blank_n,
                  if_b.vga_clk, if_b.frame_start);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 pix = 24'($urandom);
    end
  endtask

  // Reference model update.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        ma = MS_RST;
        mb = MS_RST;
      end else begin
        ma = step(GA, ma, pix, vga_reset);
        mb = step(GB, mb, pix, vga_reset);
      end
    end
  end

  // Per-cycle comparison plus whole-line / whole-frame measurements.
  initial begin
    int seen = 0, last_fs = -1, bl_cnt = 0, vs_run = 0, hs_run = 0;
    bit vs_arm = 0, hs_arm = 0;
    forever begin
      @(negedge clk);
      gc++;
      check_both();
      if (disturb != seen || vga_reset || !rst_n) begin
        seen    = disturb;
        last_fs = -1;
        bl_cnt  = 0;
        vs_run  = 0;
        vs_arm  = 0;
        hs_run  = 0;
        hs_arm  = 0;
      end else begin
        bl_cnt += int'(if_b.vga_blank_n);
        if (if_b.frame_start) begin
          if (last_fs >= 0) begin
            check("b.frame_period", gc - last_fs, htot(GB) * vtot(GB) * GB.dv);
            check("b.blank_cycles", bl_cnt, GB.ha * GB.va * GB.dv);
          end
          last_fs = gc;
          bl_cnt  = 0;
        end
        if (!if_b.vga_vs) vs_run++;
        else begin
          if (vs_arm && vs_run > 0) check("b.vs_width", vs_run, GB.vs * htot(GB) * GB.dv);
          vs_run = 0;
          vs_arm = 1;
        end
        if (!if_a.vga_hs) hs_run++;
        else begin
          if (hs_arm && hs_run > 0) check("a.hs_width", hs_run, GA.hs * GA.dv);
          hs_run = 0;
          hs_arm = 1;
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    vga_reset = 1'b0;
    pix       = 24'hFF8040;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    run(5500);

    // Synchronous raster restart in mid-frame.
    @(posedge clk);
    #1 vga_reset = 1'b1;
    disturb++;
    run(5);
    vga_reset = 1'b0;
    run(5200);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    disturb++;
    #1 check_both();
    #1 rst_n = 1'b1;
    run(5200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scan_generator.md
# vga_scan_generator

Display-side counterpart of the game system's VGA pixel export. It generates 640x480@60 Hz raster timing from the 50 MHz system clock and publishes the current pixel coordinate to the system's `vga_x_cord` / `vga_y_cord` inputs. It samples the 24-bit RGB word the system returns on `vgaout`, and drives the registered colour, sync, blank and pixel-clock pins of the board's VGA DAC. It also honours the system's `vgareset` output as a synchronous raster restart.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `CLK_DIV`, 2: `clk_clk` cycles per pixel; must be ≥2 and even

Ports (one clock; reset is asynchronous and active-low):
- `clk_clk`, in, 1: system clock, 50 MHz
- `reset_reset_n`, in, 1: asynchronous active-low reset
- `vga_reset`, in, 1: synchronous raster restart, active-high; driven by system `vgareset`
- `pixel_in`, in, 24: RGB colour for the current coordinate, packed as {R[23:16], G[15:8], B[7:0]}
- `vga_x_cord`, out, 10: current visible column
- `vga_y_cord`, out, 9: current visible line
- `vga_r`, `vga_g`, `vga_b`, out, 8 each: DAC colour
- `vga_hs`, out, 1: horizontal sync, active-low
- `vga_vs`, out, 1: vertical sync, active-low
- `vga_blank_n`, out, 1: low during blanking
- `vga_clk`, out, 1: DAC pixel clock
- `frame_start`, out, 1: one-`clk_clk` pulse at the start of each frame

## Operation
Dividers and counters:
- `div_cnt` counts 0..CLK_DIV-1 and wraps.
- `pix_en` is asserted when `div_cnt == CLK_DIV-1`.
- `h_cnt` counts 0..H_TOTAL-1, where H_TOTAL = 800; it advances on `pix_en`.
- `v_cnt` counts 0..V_TOTAL-1, where V_TOTAL = 525; it advances on `pix_en` when `h_cnt` wraps.
- Both wrap to 0 with no skipped or duplicated count.

Region decode from the counters, stage 0 (combinational):
- active = `h_cnt < H_ACTIVE` && `v_cnt < V_ACTIVE`.
- hs0 is low for H_ACTIVE+H_FP ≤ `h_cnt` < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- vs0 is low for 490 ≤ `v_cnt` < 492 (same form).

Coordinate outputs:
- `vga_x_cord` = `h_cnt` and `vga_y_cord` = `v_cnt[8:0]` while active.
- Both are 0 while blanked, so the system never sees an out-of-range coordinate.

Output stage (stage 1), registered on `pix_en`:
- `vga_r/g/b` take `pixel_in` if active, else 0.
- `vga_hs` ← hs0, `vga_vs` ← vs0, `vga_blank_n` ← active.
- Colour and sync leave aligned; there is no skew between them.

Other outputs:
- `vga_clk` is a registered signal, high when `div_cnt >= CLK_DIV/2`. Its rising edge therefore falls mid-pixel while the stage-1 outputs are stable.
- `frame_start` is asserted for exactly the one `clk_clk` cycle in which `pix_en` is high with `h_cnt == 0` and `v_cnt == 0`.

`vga_reset` behaviour:
- While high, `div_cnt`, `h_cnt` and `v_cnt` are forced to 0 every cycle, and stage 1 is loaded with its reset values.
- `frame_start` is suppressed while high.
- After release, counting resumes from 0,0 on the next cycle. The first `frame_start` occurs CLK_DIV-1 cycles later.

Asynchronous reset (`reset_reset_n` low):
- All registers are cleared immediately, regardless of clock.
- Reset values: counters 0; `vga_x_cord` = 0, `vga_y_cord` = 0; `vga_r/g/b` = 0; `vga_hs` = 1, `vga_vs` = 1; `vga_blank_n` = 0; `vga_clk` = 0; `frame_start` = 0.
- Reset mid-line or mid-frame discards the partial frame. There is no recovery state.

## Timing
- Coordinates change on the `clk_clk` edge after `pix_en`.
- `pixel_in` must be valid at the next `pix_en` edge, which gives CLK_DIV-1 cycles of source latency (1 cycle at 50 MHz/2).
- Coordinate-to-pin latency is exactly one pixel (CLK_DIV cycles). Pixel (x,y) appears on the pins while the counters hold the following coordinate.
- Line period is 800 pixels = 1600 `clk_clk` cycles; frame period is 525 lines = 840 000 cycles.
- hsync is 96 pixels wide; vsync is 2 lines (1600 pixels) wide. Sync edges occur only on `pix_en`-registered edges.
- The block has no backpressure and no handshake; `pixel_in` is sampled unconditionally.

## Test plan
- Reset, then run 2 frames with `pixel_in` = 24'hFF8040 -> `vga_r/g/b` read FF/80/40 exactly while `vga_blank_n` = 1. Count 640×480 blank-high pixels per frame and 840 000 cycles between `frame_start` pulses.
- Monitor one line -> `vga_hs` is low for exactly 192 cycles, starting 1 pixel after `h_cnt` reaches 656. `vga_x_cord` runs 0..639 and then holds 0 for 160 pixels.
- Drive `pixel_in` = {x[7:0], y[7:0], 8'h00} computed combinationally from the coordinate outputs -> pin colour at each active pixel equals that pixel's x,y; no off-by-one at x=0, x=639, y=0 or y=479.
- Wrap check -> at `h_cnt` 799 and `v_cnt` 524 the next count is 0/0; `vga_vs` is low for exactly 3200 cycles, covering lines 490..491.
- Pulse `vga_reset` for 5 cycles at mid-frame (x=300, y=200) -> counters read 0,0 the cycle after release, and `vga_blank_n`/`vga_hs`/`vga_vs` show 0/1/1 during the pulse. `frame_start` fires CLK_DIV-1 cycles after release.
- Assert `reset_reset_n` low asynchronously between clock edges -> every output is at its reset value before the next `clk_clk` edge. Normal timing resumes from 0,0 after release.
